// File: rtl/hilo_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit_pkg
// Purpose  : Shared types, constants and helpers for the HI/LO mul/div unit.
//            Holds the HILO operation encoding (matches the decoder), the
//            execute-side state encoding and the multiply result helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hilo_muldiv_unit_pkg;

  typedef enum logic [3:0] {
    HILO_NOP   = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MADD  = 4'd5,
    HILO_MADDU = 4'd6,
    HILO_MSUB  = 4'd7,
    HILO_MSUBU = 4'd8,
    HILO_MTHI  = 4'd9,
    HILO_MTLO  = 4'd10
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } hilo_state_t;

  // Restoring divide iterations; one more cycle is spent on the sign fix-up.
  localparam int DIV_ITER = 32;

  function automatic logic is_mul_op(input hilo_op_t op);
    return (op == HILO_MULT)  || (op == HILO_MULTU) ||
           (op == HILO_MADD)  || (op == HILO_MADDU) ||
           (op == HILO_MSUB)  || (op == HILO_MSUBU);
  endfunction

  // 64-bit result for the whole multiply class. Signed forms sign-extend both
  // operands to 64 bits; the low 64 bits of that product equal the true
  // signed 32x32 product, so one multiplier serves both signednesses.
  function automatic logic [63:0] mul_result(input hilo_op_t    op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [63:0] acc);
    logic        sgn;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] prod;
    sgn  = (op == HILO_MULT) || (op == HILO_MADD) || (op == HILO_MSUB);
    ea   = {{32{sgn & a[31]}}, a};
    eb   = {{32{sgn & b[31]}}, b};
    prod = ea * eb;
    case (op)
      HILO_MADD, HILO_MADDU: return acc + prod;
      HILO_MSUB, HILO_MSUBU: return acc - prod;
      default:               return prod;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit_if
// Purpose  : Issue/result bundle between the execute stage and the HI/LO unit.
// Signals  : op_valid/op_type/op_a/op_b  - operation presented by the pipeline
//            cancel                      - flush of in-flight or presented op
//            hilo_rd_req                 - younger instruction touches HI/LO
//            op_ready/stall/busy         - flow control back to the pipeline
//            hi/lo                       - architectural HI/LO registers
// Modports : master (pipeline side), slave (unit side)
// Revision : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_unit_if;
  import hilo_muldiv_unit_pkg::*;

  logic        op_valid;
  hilo_op_t    op_type;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_ready;
  logic        cancel;
  logic        hilo_rd_req;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op_type, op_a, op_b, cancel, hilo_rd_req,
    input  op_ready, stall, busy, hi, lo
  );

  modport slave (
    input  op_valid, op_type, op_a, op_b, cancel, hilo_rd_req,
    output op_ready, stall, busy, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit_divider.sv
`default_nettype none
// ============================================================================
// Module   : hilo_divider
// Purpose  : Iterative restoring 32/32 divider with start/done handshake.
//            start loads operand magnitudes; N_ITER shift-subtract steps
//            follow; done is raised in the next cycle with sign-corrected
//            quotient/remainder presented combinationally (fix-up cycle).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start, abort    - begin a divide / drop the one in progress
//            is_signed       - DIV (1) vs DIVU (0)
//            dividend/divisor- operands, sampled on start
//            done            - result valid this cycle (one cycle pulse)
//            quotient/remainder - results, valid while done
// Revision : 1.0 - initial release
// ============================================================================
module hilo_divider
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int N_ITER = DIV_ITER
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic        abort,
  input  wire logic        is_signed,
  input  wire logic [31:0] dividend,
  input  wire logic [31:0] divisor,
  output logic             done,
  output logic [31:0]      quotient,
  output logic [31:0]      remainder
);

  localparam logic [5:0] C_LAST = 6'(N_ITER);

  logic        active_q, active_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [31:0] rem_q,    rem_d;
  logic [31:0] quo_q,    quo_d;
  logic [31:0] dvs_q,    dvs_d;
  logic        qneg_q,   qneg_d;
  logic        rneg_q,   rneg_d;

  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_a_neg;
  logic        w_b_neg;

  assign w_a_neg = is_signed & dividend[31];
  assign w_b_neg = is_signed & divisor[31];
  // Partial remainder shifted left by one with the next dividend bit in.
  assign w_shift = {rem_q, quo_q[31]};
  assign w_trial = w_shift - {1'b0, dvs_q};

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = 6'd0;
      rem_d    = 32'd0;
      quo_d    = w_a_neg ? (32'd0 - dividend) : dividend;
      dvs_d    = w_b_neg ? (32'd0 - divisor)  : divisor;
      qneg_d   = w_a_neg ^ w_b_neg;
      rneg_d   = w_a_neg;
    end else if (active_q) begin
      if (cnt_q == C_LAST) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 6'd1;
        if (!w_trial[32]) begin
          // Trial subtraction did not borrow: keep it, quotient bit is 1.
          rem_d = w_trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = w_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
  // 0x80000000 / -1 negates twice to 0x80000000, the expected wrap.
  assign done      = active_q & (cnt_q == C_LAST);
  assign quotient  = qneg_q ? (32'd0 - quo_q) : quo_q;
  assign remainder = rneg_q ? (32'd0 - rem_q) : rem_q;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : Execute-stage owner of HI/LO. Runs multiply, multiply-accumulate
//            and divide in the background and stalls only younger HILO users
//            (or new HILO ops) while an operation is in flight.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - hilo_muldiv_unit_if.slave: op_valid/op_type/op_a/op_b,
//                   cancel, hilo_rd_req in; op_ready, stall, busy, hi, lo out
// Params   : MUL_LATENCY - busy cycles for the multiply class (1..8)
//            DIV_CYCLES  - busy cycles for DIV/DIVU (fixed at 33)
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_CYCLES  = 33
) (
  input  wire logic          clk,
  input  wire logic          rst,
  hilo_muldiv_unit_if.slave  bus
);

  localparam logic [2:0] C_MUL_LAST = 3'(MUL_LATENCY - 1);

  hilo_state_t state_q, state_d;
  logic        busy_q,  busy_d;
  logic [2:0]  cnt_q,   cnt_d;
  hilo_op_t    op_q,    op_d;
  logic [31:0] a_q,     a_d;
  logic [31:0] b_q,     b_d;
  logic [63:0] acc_q,   acc_d;
  logic        dz_q,    dz_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;

  logic        w_accept;
  logic        w_div_start;
  logic        w_div_done;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;
  logic [63:0] w_mul_res;

  // cancel discards an op presented in the same cycle, MTHI/MTLO included.
  assign w_accept    = bus.op_valid & ~busy_q & ~bus.cancel;
  assign w_div_start = w_accept & ((bus.op_type == HILO_DIV) ||
                                   (bus.op_type == HILO_DIVU));
  assign w_mul_res   = mul_result(op_q, a_q, b_q, acc_q);

  hilo_divider #(
    .N_ITER (DIV_CYCLES - 1)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .abort     (bus.cancel),
    .is_signed (bus.op_type == HILO_DIV),
    .dividend  (bus.op_a),
    .divisor   (bus.op_b),
    .done      (w_div_done),
    .quotient  (w_div_quo),
    .remainder (w_div_rem)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          if (bus.op_type == HILO_MTHI) begin
            hi_d = bus.op_a;
          end else if (bus.op_type == HILO_MTLO) begin
            lo_d = bus.op_a;
          end else if (is_mul_op(bus.op_type)) begin
            state_d = MUL;
            busy_d  = 1'b1;
            cnt_d   = C_MUL_LAST;
            op_d    = bus.op_type;
            a_d     = bus.op_a;
            b_d     = bus.op_b;
            // Accumulate ops use HI/LO as they stand at acceptance.
            acc_d   = {hi_q, lo_q};
          end else if (w_div_start) begin
            state_d = DIV;
            busy_d  = 1'b1;
            dz_d    = (bus.op_b == 32'd0);
          end
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == 3'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          hi_d    = w_mul_res[63:32];
          lo_d    = w_mul_res[31:0];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DIV: begin
        if (bus.cancel) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (w_div_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          // Divide by zero burns the full latency but leaves HI/LO alone.
          if (!dz_q) begin
            hi_d = w_div_rem;
            lo_d = w_div_quo;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 3'd0;
      op_q    <= HILO_NOP;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.op_ready = ~busy_q;
  assign bus.busy     = busy_q;
  assign bus.stall    = busy_q & (bus.hilo_rd_req | bus.op_valid);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execute-side counterpart to the alpha decoder's HILO classification.
- Owns the architectural HI/LO registers and executes multi-cycle multiply, multiply-accumulate and divide operations in the background.
- Raises a stall only when a later instruction that the decoder flagged as HILO-accessing arrives while an operation is still in flight.
- Sits beside the ALU in the execute stage; results become visible to MFHI/MFLO through registered hi/lo outputs.

Parameters:
- MUL_LATENCY, 3, cycles busy for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (legal range 1..8).
- DIV_CYCLES, 33, cycles busy for DIV/DIVU: 32 restoring iterations plus 1 sign fix-up (fixed; parameter for documentation/assertions only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  operation presented this cycle.
- op_type  in  4  hilo_op_t operation code.
- op_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
- op_b  in  32  rt operand (divisor / multiplier).
- op_ready  out  1  high when idle; an op is accepted iff op_valid & op_ready.
- cancel  in  1  exception/flush: abort the in-flight op or the op being presented.
- hilo_rd_req  in  1  a younger instruction needs HI/LO this cycle (decoder's is_hilo_accessed).
- stall  out  1  combinational: busy & (hilo_rd_req | op_valid).
- busy  out  1  operation in flight.
- hi  out  32  architectural HI (registered).
- lo  out  32  architectural LO (registered).

Behaviour:
- Reset values: hi=0, lo=0, busy=0, op_ready=1, state IDLE, all counters 0.
- State machine has three states: IDLE, MUL, DIV.
  - IDLE: op_ready=1. Acceptance rules on an accepted op at edge T:
    - HILO_NOP: no effect.
    - MTHI/MTLO: write op_a to hi or lo; the new value is visible in cycle T+1; the unit stays in IDLE and busy is never asserted.
    - Multiply class: operands are latched and the state moves to MUL.
    - DIVU/DIV: operands are latched and the state moves to DIV.
  - MUL: busy=1 for exactly MUL_LATENCY cycles (T+1..T+MUL_LATENCY).
    - The result is written at the end of the last busy cycle, so hi/lo are new and busy=0 at T+MUL_LATENCY+1.
  - DIV: busy=1 for 33 cycles (T+1..T+33).
    - Magnitudes are taken first for signed operations, followed by 32 restoring shift-subtract steps and 1 sign fix-up cycle.
    - hi/lo are new at T+34.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64.
  - MADD/MADDU: {hi,lo} += product, modulo 2^64. MSUB/MSUBU: {hi,lo} -= product, modulo 2^64.
  - Accumulate ops use the {hi,lo} value captured at acceptance.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Boundaries:
  - Divide by zero (op_b=0): the full 33-cycle latency still elapses; hi and lo are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps).
  - op_valid while busy: the op is ignored and op_ready=0; stall=1 so upstream holds.
  - cancel while busy: the unit returns to IDLE next cycle, hi/lo are unchanged, and busy=0 next cycle.
  - cancel in the same cycle as an accept attempt: the op is discarded, including MTHI/MTLO.
  - cancel in the final busy cycle: cancel wins and no write-back occurs.
  - hilo_rd_req while idle: stall=0; hi/lo already hold the committed values.
  - rst mid-operation: everything returns to reset values next cycle, and the in-flight result is lost.

Decomposition:
- Shared package (e.g. the existing common header/package):
  - hilo_op_t enum: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10.
  - hilo_state_t enum: IDLE, MUL, DIV.
  - Constant DIV_ITER=32.
- One natural sub-module: hilo_divider. It is the iterative restoring divider with a start/done handshake, and holds the counter, partial remainder and sign fix-up.
- The multiplier is an inline registered product plus a latency counter.

Test Plan:
- MTHI op_a=0x12345678 then MTLO op_a=0x9ABCDEF0 on consecutive cycles -> hi=0x12345678 at T+1, lo=0x9ABCDEF0 at T+2, busy never 1.
- MULT 0xFFFFFFFE x 0x00000003 (MUL_LATENCY=3) -> busy T+1..T+3; hi=0xFFFFFFFF, lo=0xFFFFFFFA at T+4. Then MADDU with hi=0, lo=0xFFFFFFFF, operands 1 x 1 -> hi=1, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at T+34. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 5/0 with hi=0xAAAA0000, lo=0x0000BBBB -> busy 33 cycles, then hi/lo unchanged.
- MULTU issued, then hilo_rd_req=1 at T+1 -> stall=1 through T+3 and 0 at T+4. op_valid presented at T+2 is not accepted.
- DIVU in flight, cancel at T+10 (and separately at T+33) -> busy=0 next cycle, hi/lo unchanged. rst at T+5 of a MULT -> hi=lo=0, busy=0.
